// File: rtl/generator.sv
// ============================================================================
// generator : odometer-style candidate generator for an external MD5 core
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module generator #(
   parameter int HASH_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          prog,
   input  logic          initiate,
   input  logic [1015:0] prg_format,
   input  logic [7:0]    prg_num_characters,
   input  logic [7:0]    prg_len,
   input  logic [127:0]  prg_h_goal,
   input  logic [127:0]  h_res,
   output logic [447:0]  m,
   output logic [63:0]   m_len,
   output logic [7:0]    state
);

   localparam int         C_MAX_LEN = 55;
   localparam logic [7:0] C_LAT     = 8'(HASH_LAT);

   typedef enum logic [7:0] {
      S_IDLE      = 8'h00,
      S_LOADED    = 8'h01,
      S_RUN       = 8'h02,
      S_WAIT      = 8'h03,
      S_FOUND     = 8'h04,
      S_EXHAUSTED = 8'h05
   } state_t;

   state_t         state_q, state_d;
   logic [1015:0]  fmt_q, fmt_d;
   logic [6:0]     n_q, n_d;
   logic [5:0]     len_q, len_d;
   logic [127:0]   goal_q, goal_d;
   logic [6:0]     dig_q [C_MAX_LEN];
   logic [6:0]     dig_d [C_MAX_LEN];
   logic [7:0]     cnt_q, cnt_d;
   logic [447:0]   m_q, m_d;
   logic [63:0]    m_len_q, m_len_d;

   logic [6:0]     n_in;
   logic [5:0]     len_in;
   logic [6:0]     n_max;
   logic [6:0]     dig_inc [C_MAX_LEN];
   logic           all_max;
   logic           carry;
   logic           new_cand;

   // Character index d lives at byte N-1-d so index 0 is the leftmost string char.
   function automatic logic [7:0] char_at(input logic [1015:0] fmt,
                                          input logic [6:0]    n,
                                          input logic [6:0]    d);
      logic [6:0] idx;
      idx = n - 7'd1 - d;
      return fmt[{idx, 3'b000} +: 8];
   endfunction

   assign n_in   = (prg_num_characters == 8'd0)  ? 7'd1  :
                   (prg_num_characters > 8'd127) ? 7'd127 : prg_num_characters[6:0];
   assign len_in = (prg_len == 8'd0)  ? 6'd1  :
                   (prg_len > 8'd55)  ? 6'd55 : prg_len[5:0];
   assign n_max  = n_q - 7'd1;

   always_comb begin
      carry   = 1'b1;
      all_max = 1'b1;
      for (int i = 0; i < C_MAX_LEN; i++) begin
         dig_inc[i] = 7'd0;
         if (6'(i) < len_q) begin
            all_max    = all_max & (dig_q[i] == n_max);
            dig_inc[i] = dig_q[i];
            if (carry) begin
               if (dig_q[i] == n_max) begin
                  dig_inc[i] = 7'd0;
               end else begin
                  dig_inc[i] = dig_q[i] + 7'd1;
                  carry      = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      fmt_d    = fmt_q;
      n_d      = n_q;
      len_d    = len_q;
      goal_d   = goal_q;
      dig_d    = dig_q;
      cnt_d    = cnt_q;
      m_d      = m_q;
      m_len_d  = m_len_q;
      new_cand = 1'b0;

      case (state_q)
         S_RUN, S_WAIT: begin
            if (cnt_q == 8'd0) begin
               if (h_res == goal_q) begin
                  state_d = S_FOUND;
               end else if (all_max) begin
                  state_d = S_EXHAUSTED;
               end else begin
                  dig_d    = dig_inc;
                  state_d  = S_RUN;
                  cnt_d    = C_LAT;
                  new_cand = 1'b1;
               end
            end else begin
               state_d = S_WAIT;
               cnt_d   = cnt_q - 8'd1;
            end
         end
         default: begin
            if (prog) begin
               fmt_d   = prg_format;
               n_d     = n_in;
               len_d   = len_in;
               goal_d  = prg_h_goal;
               m_len_d = {55'd0, len_in, 3'b000};
               state_d = S_LOADED;
            end else if (initiate && state_q != S_IDLE) begin
               for (int i = 0; i < C_MAX_LEN; i++) dig_d[i] = 7'd0;
               state_d  = S_RUN;
               cnt_d    = C_LAT;
               new_cand = 1'b1;
            end
         end
      endcase

      if (new_cand) begin
         for (int i = 0; i < C_MAX_LEN; i++)
            m_d[8*i +: 8] = (6'(i) < len_q) ? char_at(fmt_q, n_q, dig_d[i]) : 8'h00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         fmt_q   <= '0;
         n_q     <= '0;
         len_q   <= '0;
         goal_q  <= '0;
         cnt_q   <= '0;
         m_q     <= '0;
         m_len_q <= '0;
         for (int i = 0; i < C_MAX_LEN; i++) dig_q[i] <= 7'd0;
      end else begin
         state_q <= state_d;
         fmt_q   <= fmt_d;
         n_q     <= n_d;
         len_q   <= len_d;
         goal_q  <= goal_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         m_len_q <= m_len_d;
         for (int i = 0; i < C_MAX_LEN; i++) dig_q[i] <= dig_d[i];
      end
   end

   assign m     = m_q;
   assign m_len = m_len_q;
   assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_generator.sv
// ============================================================================
// tb_generator : randomized scoreboard bench for the candidate generator
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_generator;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          prog = 1'b0;
   logic          initiate = 1'b0;
   logic [1015:0] prg_format = '0;
   logic [7:0]    prg_num_characters = '0;
   logic [7:0]    prg_len = '0;
   logic [127:0]  prg_h_goal = '0;
   logic [127:0]  h_res;
   logic [447:0]  m;
   logic [63:0]   m_len;
   logic [7:0]    state;

   int            checks = 0;
   int            errors = 0;
   logic [447:0]  exp_q[$];
   bit            mon_en = 1'b0;
   byte unsigned  cs[127];
   logic [447:0]  tgt_m = '0;
   bit            tgt_en = 1'b0;
   logic [127:0]  goal = '0;

   generator #(.HASH_LAT(1)) dut (
      .clk(clk), .rst(rst), .prog(prog), .initiate(initiate),
      .prg_format(prg_format), .prg_num_characters(prg_num_characters),
      .prg_len(prg_len), .prg_h_goal(prg_h_goal), .h_res(h_res),
      .m(m), .m_len(m_len), .state(state)
   );

   always #5 clk = ~clk;

   // Stand-in hash core: matches the goal only for the chosen target string.
   assign h_res = (tgt_en && m == tgt_m) ? goal : ~goal;

   task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Candidate k is k written in base n, least significant digit at m[7:0].
   function automatic logic [447:0] model_m(input int k, input int n, input int l);
      logic [447:0] r;
      int v;
      r = '0;
      v = k;
      for (int i = 0; i < l; i++) begin
         r[8*i +: 8] = cs[v % n];
         v = v / n;
      end
      return r;
   endfunction

   function automatic logic [1015:0] build_fmt(input int n);
      logic [1015:0] f;
      f = '0;
      for (int i = 0; i < n; i++) f[8*(n-1-i) +: 8] = cs[i];
      return f;
   endfunction

   always @(negedge clk) begin
      if (mon_en && state == 8'h02) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cand_extra actual=%0h required=none", m);
         end else begin
            chk("cand", m, exp_q.pop_front());
         end
      end
   end

   task automatic run_trial(input int n_raw, input int l_raw, input int tgt, input bit poke);
      int n, l, total, last, cyc;
      n = (n_raw == 0) ? 1 : (n_raw > 127) ? 127 : n_raw;
      l = (l_raw == 0) ? 1 : (l_raw > 55) ? 55 : l_raw;
      total = 1;
      for (int i = 0; i < l; i++) total = total * n;
      last = (tgt >= 0) ? tgt : total - 1;
      goal = {$urandom, $urandom, $urandom, $urandom};

      @(negedge clk);
      prg_format = build_fmt(n);
      prg_num_characters = 8'(n_raw);
      prg_len = 8'(l_raw);
      prg_h_goal = goal;
      prog = 1'b1;
      @(negedge clk);
      prog = 1'b0;
      chk("load_state", 448'(state), 448'h01);
      chk("load_mlen", 448'(m_len), 448'(8 * l));

      tgt_en = (tgt >= 0);
      tgt_m = (tgt >= 0) ? model_m(tgt, n, l) : '0;
      for (int k = 0; k <= last; k++) exp_q.push_back(model_m(k, n, l));
      mon_en = 1'b1;
      initiate = 1'b1;
      @(negedge clk);
      initiate = 1'b0;

      if (poke && last > 3) begin
         @(negedge clk);
         prg_len = 8'd3;
         prog = 1'b1;
         @(negedge clk);
         prog = 1'b0;
      end

      cyc = 0;
      while (state != 8'h04 && state != 8'h05 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 4000) begin
         checks++;
         errors++;
         $display("FAIL timeout actual=%0h required=04_or_05", state);
      end
      chk("end_state", 448'(state), (tgt >= 0) ? 448'h04 : 448'h05);
      chk("end_m", m, model_m(last, n, l));
      repeat (3) @(negedge clk);
      chk("hold_state", 448'(state), (tgt >= 0) ? 448'h04 : 448'h05);
      chk("hold_m", m, model_m(last, n, l));
      chk("queue_empty", 448'(exp_q.size()), 448'd0);
      mon_en = 1'b0;
      exp_q.delete();
      tgt_en = 1'b0;
   endtask

   initial begin
      string s;
      int n, l, total, tgt, off;

      // Asynchronous reset before any clock edge has occurred.
      #3 rst = 1'b1;
      #1;
      chk("rst_state", 448'(state), 448'h00);
      chk("rst_m", m, 448'h0);
      chk("rst_mlen", 448'(m_len), 448'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      @(negedge clk); initiate = 1'b1;
      @(negedge clk); initiate = 1'b0;
      chk("idle_initiate", 448'(state), 448'h00);

      // 36-char charset, L=5.
      s = "abcdefghijklmnopqrstuvwxyz1234567890";
      for (int i = 0; i < 36; i++) cs[i] = s[i];
      goal = '1;
      tgt_en = 1'b0;
      @(negedge clk);
      prg_format = build_fmt(36);
      prg_num_characters = 8'd36;
      prg_len = 8'd5;
      prg_h_goal = goal;
      prog = 1'b1;
      repeat (2) @(negedge clk);
      prog = 1'b0;
      chk("abc_state", 448'(state), 448'h01);
      chk("abc_mlen", 448'(m_len), 448'd40);
      initiate = 1'b1;
      @(negedge clk);
      initiate = 1'b0;
      chk("abc_run", 448'(state), 448'h02);
      chk("abc_aaaaa", m, 448'h6161616161);
      repeat (2) @(negedge clk);
      chk("abc_aaaab", m, 448'h6161616162);
      @(negedge clk);
      chk("abc_wait", 448'(state), 448'h03);

      // Abort mid-search with an asynchronous reset.
      #2 rst = 1'b1;
      #1;
      chk("abort_state", 448'(state), 448'h00);
      chk("abort_m", m, 448'h0);
      chk("abort_mlen", 448'(m_len), 448'h0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); initiate = 1'b1;
      @(negedge clk); initiate = 1'b0;
      @(negedge clk);
      chk("abort_initiate", 448'(state), 448'h00);

      // "ab" charset: exhaust, then match on "ab".
      cs[0] = 8'h61;
      cs[1] = 8'h62;
      run_trial(2, 2, -1, 1'b0);
      chk("exh_bb", m, 448'h6262);
      run_trial(2, 2, 1, 1'b0);
      chk("found_ab", m, 448'h6162);

      @(negedge clk);
      prog = 1'b1;
      initiate = 1'b1;
      @(negedge clk);
      prog = 1'b0;
      initiate = 1'b0;
      chk("prio_state", 448'(state), 448'h01);

      // Clamping: L=0/N=0 behaves as one candidate.
      cs[0] = 8'h7a;
      run_trial(0, 0, -1, 1'b0);

      @(negedge clk);
      prg_len = 8'd200;
      prg_num_characters = 8'd200;
      prog = 1'b1;
      @(negedge clk);
      prog = 1'b0;
      chk("clamp_mlen", 448'(m_len), 448'd440);
      chk("clamp_state", 448'(state), 448'h01);

      repeat (8) begin
         n = $urandom_range(2, 5);
         l = $urandom_range(1, 4);
         off = $urandom_range(33, 60);
         for (int i = 0; i < n; i++) cs[i] = 8'(off + 3 * i);
         total = 1;
         for (int i = 0; i < l; i++) total = total * n;
         tgt = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, total - 1);
         run_trial(n, l, tgt, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
